// File: rtl/serializer.sv
// Haraka-S transmit serializer: squeezed blocks in, OUT_WIDTH packets out.
// Define SERIALIZER_MSB_FIRST_EN to emit the top of each block first.
module serializer #(
    parameter int IN_WIDTH         = 256,
    parameter int OUT_WIDTH        = 8,
    parameter int PACKETS_IN_BLOCK = IN_WIDTH / OUT_WIDTH,
    parameter int PKT_CNT_WIDTH    = $clog2(PACKETS_IN_BLOCK),
    parameter int LEN_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] out_len,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 squeeze_req,
    output logic [OUT_WIDTH-1:0] serial_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLOCK,
        SHIFT,
        DONE
    } state_t;

    localparam logic [PKT_CNT_WIDTH-1:0] LAST_PKT =
        PKT_CNT_WIDTH'(PACKETS_IN_BLOCK - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [IN_WIDTH-1:0]    shift_q;
    logic [LEN_WIDTH-1:0]   remaining_q;
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q;
    logic                   zero_done_q;

    logic start_go;
    logic start_zero;
    logic blk_fire;
    logic pkt_fire;

    assign start_go   = (state_q == IDLE) && start && (out_len != '0);
    assign start_zero = (state_q == IDLE) && start && (out_len == '0);
    assign blk_fire   = (state_q == WAIT_BLOCK) && in_valid;
    assign pkt_fire   = (state_q == SHIFT) && out_ready;

    // State register; clear aborts any transfer immediately.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; outputs depend on state/registers only.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        squeeze_req = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        serial_out  = '0;
        busy        = 1'b1;
        done        = zero_done_q;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start_go) begin
                    state_d = WAIT_BLOCK;
                end
            end
            WAIT_BLOCK: begin
                in_ready    = 1'b1;
                squeeze_req = 1'b1;
                if (in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                out_last  = (remaining_q == LEN_WIDTH'(1));
`ifdef SERIALIZER_MSB_FIRST_EN
                serial_out = shift_q[IN_WIDTH-1 -: OUT_WIDTH];
`else
                serial_out = shift_q[OUT_WIDTH-1:0];
`endif
                if (out_ready) begin
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end else if (pkt_cnt_q == LAST_PKT) begin
                        state_d = WAIT_BLOCK;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: block load, packet shift, length and index bookkeeping.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            shift_q     <= '0;
            remaining_q <= '0;
            pkt_cnt_q   <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= start_zero;
            if (start_go) begin
                remaining_q <= out_len;
            end
            if (blk_fire) begin
                shift_q   <= in_data;
                pkt_cnt_q <= '0;
            end
            if (pkt_fire) begin
`ifdef SERIALIZER_MSB_FIRST_EN
                shift_q <= shift_q << OUT_WIDTH;
`else
                shift_q <= shift_q >> OUT_WIDTH;
`endif
                remaining_q <= remaining_q - LEN_WIDTH'(1);
                pkt_cnt_q   <= pkt_cnt_q + PKT_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Directed self-checking bench for serializer.
// Honours SERIALIZER_MSB_FIRST_EN when the build defines it.
module tb_serializer;

    logic         clk = 1'b0;
    logic         clear;
    logic         start;
    logic [15:0]  out_len;
    logic [255:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         squeeze_req;
    logic [7:0]   serial_out;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] pk_data[$];
    logic       pk_last[$];
    int         pk_cyc[$];
    int         blk_cnt;
    int         blk_cyc;
    int         done_cnt;
    int         done_cyc;

    serializer #(
        .IN_WIDTH(256),
        .OUT_WIDTH(8),
        .LEN_WIDTH(16)
    ) dut (
        .clk(clk),
        .clear(clear),
        .start(start),
        .out_len(out_len),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .squeeze_req(squeeze_req),
        .serial_out(serial_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp observed events.
    always @(posedge clk) cyc++;

    // Record handshakes and done pulses mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (!clear) begin
            if (out_valid && out_ready) begin
                pk_data.push_back(serial_out);
                pk_last.push_back(out_last);
                pk_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                blk_cnt++;
                blk_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        pk_data.delete();
        pk_last.delete();
        pk_cyc.delete();
        blk_cnt  = 0;
        blk_cyc  = 0;
        done_cnt = 0;
        done_cyc = 0;
    endtask

    function automatic logic [255:0] mk_block(input logic [7:0] base);
        logic [255:0] b;
        for (int k = 0; k < 32; k++) b[k*8 +: 8] = base + 8'(k);
        return b;
    endfunction

    function automatic logic [7:0] exp_pkt(input logic [7:0] base,
                                           input int j);
`ifdef SERIALIZER_MSB_FIRST_EN
        return base + 8'(31 - j);
`else
        return base + 8'(j);
`endif
    endfunction

    task automatic start_xfer(input logic [15:0] len);
        out_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic feed_block(input logic [255:0] blk, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            in_data  = blk;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        #1;
        checks++;
        if ({in_ready, squeeze_req, out_valid, out_last, busy, done} !== 6'b0 ||
            serial_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b sq=%b v=%b l=%b b=%b d=%b d=%h, want all 0",
                     in_ready, squeeze_req, out_valid, out_last, busy, done, serial_out);
        end
        tick();
        tick();
        clear = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b in_ready=%b, want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_single_block();
        bit ok;
        clear_log();
        out_ready = 1'b1;
        start_xfer(16'd32);
        checks++;
        if (in_ready !== 1'b1 || squeeze_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_wait_block: rdy=%b sq=%b busy=%b, want 1 1 1",
                     in_ready, squeeze_req, busy);
        end
        feed_block(mk_block(8'h00), ok);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t1_done_timeout: done not seen, want pulse");
        end
        checks++;
        if (pk_data.size() != 32) begin
            errors++;
            $display("FAIL t1_count: got %0d packets, want 32", pk_data.size());
        end
        for (int j = 0; j < 32 && j < pk_data.size(); j++) begin
            checks++;
            if (pk_data[j] !== exp_pkt(8'h00, j) || pk_last[j] !== (j == 31) ||
                pk_cyc[j] != pk_cyc[0] + j) begin
                errors++;
                $display("FAIL t1_pkt%0d: got %h last=%b cyc=%0d, want %h last=%b cyc=%0d",
                         j, pk_data[j], pk_last[j], pk_cyc[j], exp_pkt(8'h00, j),
                         (j == 31), pk_cyc[0] + j);
            end
        end
        checks++;
        if (pk_data.size() != 0 && pk_cyc[0] != blk_cyc + 1) begin
            errors++;
            $display("FAIL t1_latency: first pkt cyc %0d, want %0d", pk_cyc[0], blk_cyc + 1);
        end
        checks++;
        if (blk_cnt != 1 || done_cnt != 1 ||
            (pk_cyc.size() == 32 && done_cyc != pk_cyc[31] + 1)) begin
            errors++;
            $display("FAIL t1_done: blocks=%0d dones=%0d done_cyc=%0d, want 1 1 last+1",
                     blk_cnt, done_cnt, done_cyc);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_two_blocks();
        bit ok;
        logic [7:0] e;
        clear_log();
        out_ready = 1'b1;
        start_xfer(16'd40);
        feed_block(mk_block(8'h00), ok);
        tick();
        feed_block(mk_block(8'h80), ok);
        checks++;
        if (!ok || blk_cnt != 2) begin
            errors++;
            $display("FAIL t2_second_block: ok=%b blocks=%0d, want 1 2", ok, blk_cnt);
        end
        wait_done(ok);
        checks++;
        if (!ok || pk_data.size() != 40) begin
            errors++;
            $display("FAIL t2_count: done=%b packets=%0d, want 1 40", ok, pk_data.size());
        end
        for (int j = 0; j < 40 && j < pk_data.size(); j++) begin
            e = (j < 32) ? exp_pkt(8'h00, j) : exp_pkt(8'h80, j - 32);
            checks++;
            if (pk_data[j] !== e || pk_last[j] !== (j == 39)) begin
                errors++;
                $display("FAIL t2_pkt%0d: got %h last=%b, want %h last=%b",
                         j, pk_data[j], pk_last[j], e, (j == 39));
            end
        end
        checks++;
        if (pk_cyc.size() == 40 && pk_cyc[32] != pk_cyc[31] + 2) begin
            errors++;
            $display("FAIL t2_bubble: pkt32 cyc %0d, want %0d", pk_cyc[32], pk_cyc[31] + 2);
        end
        tick();
        checks++;
        if (squeeze_req !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || blk_cnt != 2) begin
            errors++;
            $display("FAIL t2_after: sq=%b rdy=%b busy=%b blocks=%0d, want 0 0 0 2",
                     squeeze_req, in_ready, busy, blk_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [15:0] pat;
        logic       pv, pr, pl;
        logic [7:0] pd;
        pat = 16'b1001_0110_0011_0100;
        clear_log();
        out_ready = 1'b0;
        start_xfer(16'd5);
        feed_block(mk_block(8'h00), ok);
        for (int i = 0; i < 100 && done_cnt == 0; i++) begin
            out_ready = pat[i % 16];
            pv = out_valid;
            pr = out_ready;
            pd = serial_out;
            pl = out_last;
            tick();
            if (pv && !pr) begin
                checks++;
                if (serial_out !== pd || out_last !== pl || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL t3_stall_stable: got %h last=%b v=%b, want %h last=%b v=1",
                             serial_out, out_last, out_valid, pd, pl);
                end
            end
        end
        out_ready = 1'b1;
        checks++;
        if (done_cnt != 1 || pk_data.size() != 5) begin
            errors++;
            $display("FAIL t3_count: dones=%0d packets=%0d, want 1 5", done_cnt, pk_data.size());
        end
        for (int j = 0; j < 5 && j < pk_data.size(); j++) begin
            checks++;
            if (pk_data[j] !== exp_pkt(8'h00, j) || pk_last[j] !== (j == 4)) begin
                errors++;
                $display("FAIL t3_pkt%0d: got %h last=%b, want %h last=%b",
                         j, pk_data[j], pk_last[j], exp_pkt(8'h00, j), (j == 4));
            end
        end
        tick();
    endtask

    task automatic test_zero_len();
        clear_log();
        out_len = 16'd0;
        start   = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL t4_pre: rdy=%b done=%b, want 0 0", in_ready, done);
        end
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL t4_pulse: done=%b busy=%b rdy=%b, want 1 0 0", done, busy, in_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || squeeze_req !== 1'b0 || blk_cnt != 0) begin
            errors++;
            $display("FAIL t4_after: done=%b busy=%b sq=%b blocks=%0d, want 0 0 0 0",
                     done, busy, squeeze_req, blk_cnt);
        end
    endtask

    task automatic test_clear_abort();
        bit ok;
        clear_log();
        out_ready = 1'b1;
        start_xfer(16'd32);
        feed_block(mk_block(8'h00), ok);
        for (int i = 0; i < 50 && pk_data.size() < 10; i++) tick();
        checks++;
        if (pk_data.size() != 10 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t5_pre: packets=%0d v=%b, want 10 1", pk_data.size(), out_valid);
        end
        clear = 1'b1;
        #1;
        checks++;
        if ({in_ready, squeeze_req, out_valid, out_last, busy, done} !== 6'b0 ||
            serial_out !== 8'h00) begin
            errors++;
            $display("FAIL t5_clear: rdy=%b sq=%b v=%b l=%b b=%b d=%b d=%h, want all 0",
                     in_ready, squeeze_req, out_valid, out_last, busy, done, serial_out);
        end
        tick();
        clear = 1'b0;
        tick();
        clear_log();
        start_xfer(16'd3);
        feed_block(mk_block(8'h40), ok);
        wait_done(ok);
        checks++;
        if (!ok || pk_data.size() != 3) begin
            errors++;
            $display("FAIL t5_restart: done=%b packets=%0d, want 1 3", ok, pk_data.size());
        end
        for (int j = 0; j < 3 && j < pk_data.size(); j++) begin
            checks++;
            if (pk_data[j] !== exp_pkt(8'h40, j) || pk_last[j] !== (j == 2)) begin
                errors++;
                $display("FAIL t5_pkt%0d: got %h last=%b, want %h last=%b",
                         j, pk_data[j], pk_last[j], exp_pkt(8'h40, j), (j == 2));
            end
        end
        tick();
    endtask

    initial begin
        clear     = 1'b1;
        start     = 1'b0;
        out_len   = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        blk_cnt   = 0;
        done_cnt  = 0;
        test_reset();
        test_single_block();
        test_two_blocks();
        test_backpressure();
        test_zero_len();
        test_clear_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
